// File: rtl/reaction_responder.sv
// Automatic button player for the reaction timer: presses start, waits for the
// stimulus LED to rise, holds off a programmed delay, presses stop and reports the reaction time.
`timescale 1ns/1ps
module reaction_responder #(
  parameter int DELAY_W      = 24,
  parameter int PRESS_CYCLES = 10,
  parameter int TIMEOUT_CYC  = 30000000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               en,
  input  logic               start_req,
  input  logic [DELAY_W-1:0] delay_cyc,
  input  logic               led_in,
  output logic               btn_start,
  output logic               btn_stop,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [DELAY_W-1:0] measured,
  output logic [2:0]         state_dbg
);

  // The run counter also times the ARM window, so it is widened when the
  // timeout does not fit in DELAY_W bits.
  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = (TO_W > DELAY_W) ? TO_W : DELAY_W;

  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_PRESS = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [SS-1:0]      sync_q;
  logic               led_prev_q;
  logic               led_s;
  logic               led_rise;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic               timeout_q, timeout_d;
  logic [DELAY_W-1:0] measured_q, measured_d;
  logic [DELAY_W-1:0] cnt_lo, meas_next;
  logic               btn_start_q, btn_stop_q, done_q;

  assign led_s    = sync_q[SS-1];
  assign led_rise = led_s & ~led_prev_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      led_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SS-2:0], led_in};
      led_prev_q <= led_s;
    end
  end

  // Saturating counter; never wraps back to zero.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_lo    = cnt_q[DELAY_W-1:0];
  assign meas_next = (&cnt_lo) ? cnt_lo : cnt_lo + DELAY_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    dly_d      = dly_q;
    timeout_d  = timeout_q;
    measured_d = measured_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_req && en) begin
          state_d   = S_START;
          dly_d     = delay_cyc;
          timeout_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == PRESS_LAST) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        // Only a fresh rise counts; a LED already high on entry shows no edge.
        if (led_rise) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(dly_q)) begin
          state_d    = S_PRESS;
          cnt_d      = '0;
          measured_d = meas_next;
        end
      end
      S_PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort wins over everything; results from earlier runs are kept.
    if (!en) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      dly_d      = dly_q;
      timeout_d  = timeout_q;
      measured_d = measured_q;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dly_q       <= '0;
      timeout_q   <= 1'b0;
      measured_q  <= '0;
      btn_start_q <= 1'b0;
      btn_stop_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      timeout_q   <= timeout_d;
      measured_q  <= measured_d;
      btn_start_q <= (state_d == S_START);
      btn_stop_q  <= (state_d == S_PRESS);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign btn_start = btn_start_q;
  assign btn_stop  = btn_stop_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign timeout   = timeout_q;
  assign measured  = measured_q;
  assign state_dbg = state_q;

endmodule
